scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered successor to the lab 3-to-8 decoder: N-bit select in, 2^N one-hot lines out, with enable.
- Adds an auto-scan mode: an internal index walks 0..LIMIT at a prescaled rate and wraps. This drives multiplexed 7-segment digit or LED-column strobing without an external counter.
- Sits between the datapath/control logic and the board display drivers.

Parameters:
- N, 3, select width; output width is 2^N.
- PRESCALE, 4, clock cycles per scan step in scan mode; legal range 1..65535.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- EN  input  1  enable; when 0, all Y lines are 0 and scan progress freezes.
- MODE  input  1  0 = direct decode of W; 1 = auto-scan.
- W  input  N  select value in direct mode; ignored in scan mode.
- LIMIT  input  N  last index of the scan sequence (inclusive); ignored in direct mode.
- Y  output  2^N  one-hot decode; Y[i] = 1 iff the line is active and index == i.
- SEL  output  N  current internal index.
- WRAP  output  1  one-cycle pulse when the scan wraps LIMIT -> 0.

Behaviour:
- State
  - idx (N bits), active flag act, prescale counter pc (width clog2(PRESCALE), minimum 1), mode_q (registered MODE), WRAP register.
- Reset (asynchronous, immediate, also mid-operation)
  - idx = 0, act = 0, pc = 0, mode_q = 0, WRAP = 0.
  - Hence Y = 0 and SEL = 0 while Reset is high and on the first edge after release.
- Outputs
  - Y = act ? (1 << idx) : 0.
  - SEL = idx.
  - Both are decoded from registers only; no combinational path from inputs to Y, SEL or WRAP.
- Direct mode (MODE = 0), each edge
  - If EN: idx <= W, act <= 1.
  - Else: act <= 0, idx holds.
  - pc <= 0 and WRAP <= 0 every edge.
  - Latency: W/EN to Y is exactly 1 clock.
- Scan mode (MODE = 1), each edge
  - If EN = 0: act <= 0; idx and pc hold; WRAP <= 0.
  - If EN = 1: act <= 1.
    - If pc == PRESCALE-1: pc <= 0 and idx steps. If idx >= LIMIT then idx <= 0 and WRAP <= 1; else idx <= idx+1 and WRAP <= 0.
    - Otherwise: pc <= pc+1 and WRAP <= 0.
- Mode change
  - On any edge where MODE != mode_q, pc <= 0, WRAP <= 0 and idx does not step. mode_q <= MODE every edge.
  - Direct -> scan: the scan resumes from the current idx and the first step occurs PRESCALE edges later.
  - Scan -> direct: W is loaded on that same edge, if EN = 1.
- Boundary conditions
  - PRESCALE = 1: idx steps on every enabled edge.
  - LIMIT = 0: idx stays at 0 and WRAP pulses on every step.
  - LIMIT lowered below idx mid-scan: the next step wraps to 0 with WRAP = 1. There is never a pass through indices above LIMIT.
  - LIMIT = 2^N-1: the full sequence, with natural wrap.
  - EN toggling in scan mode: pc holds across EN = 0, so the step cadence resumes where it stopped.
- Y is always either 0 or exactly one-hot; never multi-hot.

Test Plan:
- Reset and direct decode (N = 3): Reset pulse, then MODE = 0, EN = 1, W = 5 → one clock later Y = 8'b0010_0000, SEL = 5. Then EN = 0 → next clock Y = 0, SEL = 5.
- Full scan (N = 3, PRESCALE = 4, LIMIT = 7): MODE = 1, EN = 1 held for 40 clocks →
  - SEL walks 0,1,...,7,0 with one step every 4 clocks.
  - WRAP is high for exactly one clock at the 7 -> 0 step.
  - Y stays one-hot on every cycle.
- Short limit and limit change: LIMIT = 2 → SEL sequence 0,1,2,0,... Then, with SEL = 2, set LIMIT = 1 → next step goes to 0 with WRAP = 1.
- Enable freeze: scan with PRESCALE = 4, drop EN for 10 clocks at pc = 2 → Y = 0 and SEL is unchanged during the gap. After EN returns, the step comes 2 clocks later.
- Mode switches: in scan at SEL = 3, set MODE = 0, W = 6 → next clock SEL = 6. Set MODE = 1 → SEL stays 6 for 4 clocks, then becomes 7.
- Asynchronous reset mid-scan: assert Reset between clock edges at SEL = 4 → Y = 0, SEL = 0, WRAP = 0 immediately. After release, the scan restarts from 0 with a full PRESCALE delay.

Source files
------------

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
// In direct mode the select input W is decoded one clock later.
// In scan mode an internal index walks 0..LIMIT. It advances one step every
// PRESCALE enabled clocks and wraps back to 0. This is used for strobing
// multiplexed display digits or LED columns.
//
// Ports
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-high reset
//   EN     : enable; 0 forces Y to 0 and freezes scan progress
//   MODE   : 0 = direct decode of W, 1 = auto-scan
//   W      : direct-mode select value
//   LIMIT  : last scan index (inclusive)
//   Y      : one-hot decode of the internal index (or all zero)
//   SEL    : current internal index
//   WRAP   : one-cycle pulse on the LIMIT -> 0 scan step
//
// Every output comes from registers only.
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int N        = 3,
    parameter int PRESCALE = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              EN,
    input  logic              MODE,
    input  logic [N-1:0]      W,
    input  logic [N-1:0]      LIMIT,
    output logic [2**N-1:0]   Y,
    output logic [N-1:0]      SEL,
    output logic              WRAP
);

    // The prescale counter is never narrower than one bit, so PRESCALE = 1
    // still has a legal (always-zero) counter.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

    logic [N-1:0]  idx_reg, idx_next;
    logic          act_reg, act_next;
    logic [PW-1:0] pc_reg, pc_next;
    logic          mode_reg;
    logic          wrap_reg, wrap_next;

    always_comb begin
        idx_next  = idx_reg;
        act_next  = act_reg;
        pc_next   = pc_reg;
        wrap_next = 1'b0;

        if (!MODE) begin
            // Direct decode. This branch also covers the scan -> direct edge,
            // where W is loaded at once.
            pc_next  = '0;
            act_next = EN;
            if (EN) begin
                idx_next = W;
            end
        end else begin
            act_next = EN;
            if (mode_reg != MODE) begin
                // First scan edge: restart the cadence from the current index.
                pc_next = '0;
            end else if (EN) begin
                if (pc_reg == PC_LAST) begin
                    pc_next = '0;
                    // Using >= instead of == means a LIMIT lowered below the
                    // current index wraps on the next step. The index never
                    // passes through values above LIMIT.
                    if (idx_reg >= LIMIT) begin
                        idx_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    pc_next = pc_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx_reg  <= '0;
            act_reg  <= 1'b0;
            pc_reg   <= '0;
            mode_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            act_reg  <= act_next;
            pc_reg   <= pc_next;
            mode_reg <= MODE;
            wrap_reg <= wrap_next;
        end
    end

    // One comparator per output line. At most one line can match idx, so
    // Y is either zero or one-hot.
    generate
        for (genvar gi = 0; gi < 2**N; gi++) begin : g_line
            assign Y[gi] = act_reg && (idx_reg == N'(gi));
        end
    endgenerate

    assign SEL  = idx_reg;
    assign WRAP = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

    localparam int N        = 3;
    localparam int PRESCALE = 4;
    localparam int LINES    = 2**N;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic [N-1:0]     w;
    logic [N-1:0]     limit;
    logic [LINES-1:0] y;
    logic [N-1:0]     sel;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    // cnt counts enabled scan clocks since the last step.
    int m_idx, m_cnt;
    bit m_act, m_mode, m_wrap;

    logic [LINES-1:0] exp_y;
    logic [N-1:0]     exp_sel;
    logic             exp_wrap;

    scan_decoder #(.N(N), .PRESCALE(PRESCALE)) dut (
        .Clock(clk), .Reset(rst), .EN(en), .MODE(mode), .W(w),
        .LIMIT(limit), .Y(y), .SEL(sel), .WRAP(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_expect();
        exp_y    = m_act ? LINES'(1 << m_idx) : '0;
        exp_sel  = N'(m_idx);
        exp_wrap = m_wrap;
    endfunction

    function automatic void model_reset();
        m_idx = 0; m_cnt = 0; m_act = 0; m_mode = 0; m_wrap = 0;
        model_expect();
    endfunction

    // Model the behaviour at one clock edge, based on the sampled inputs.
    function automatic void model_edge();
        m_wrap = 0;
        m_act  = en;
        if (!mode) begin
            m_cnt = 0;
            if (en) m_idx = int'(w);
        end else if (mode != m_mode) begin
            m_cnt = 0;
        end else if (en) begin
            m_cnt++;
            if (m_cnt == PRESCALE) begin
                m_cnt = 0;
                if (m_idx >= int'(limit)) begin
                    m_idx  = 0;
                    m_wrap = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end
        m_mode = mode;
        model_expect();
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Assert reset between clock edges, then release it.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        en = 0; mode = 0; w = 0; limit = 0;
        rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if ({y, sel, wrap} !== {LINES'(0), N'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got y=%b sel=%0d wrap=%b, required all zero", y, sel, wrap);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({y, sel, wrap} !== {LINES'(0), N'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got y=%b sel=%0d wrap=%b, required all zero", y, sel, wrap);
        end
        $display("reset: y=%b sel=%0d wrap=%b", y, sel, wrap);
    endtask

    task automatic test_direct();
        mode = 0; en = 1; w = 3'd5;
        tick();
        checks++;
        if ({y, sel, wrap} !== {8'b0010_0000, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL direct_w5: got y=%b sel=%0d, required y=00100000 sel=5", y, sel);
        end
        en = 0;
        tick();
        checks++;
        if ({y, sel} !== {8'b0, 3'd5}) begin
            errors++;
            $display("FAIL direct_disable: got y=%b sel=%0d, required y=0 sel=5", y, sel);
        end
        for (int i = 0; i < 20; i++) begin
            en = ($urandom_range(0, 3) != 0);
            w  = N'($urandom);
            tick();
            checks++;
            if ({y, sel, wrap} !== {exp_y, exp_sel, exp_wrap}) begin
                errors++;
                $display("FAIL direct_rand: en=%b w=%0d got y=%b sel=%0d, required y=%b sel=%0d", en, w, y, sel, exp_y, exp_sel);
            end
            $display("direct: en=%b w=%0d y=%b sel=%0d", en, w, y, sel);
        end
    endtask

    task automatic test_full_scan();
        int wraps = 0;
        do_reset();
        limit = 3'd7; mode = 1; en = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wrap === 1'b1) wraps++;
            checks++;
            if ({y, sel, wrap} !== {exp_y, exp_sel, exp_wrap} || $countones(y) != 1) begin
                errors++;
                $display("FAIL full_scan: cyc=%0d got y=%b sel=%0d wrap=%b, required y=%b sel=%0d wrap=%b", i, y, sel, wrap, exp_y, exp_sel, exp_wrap);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL full_scan_wraps: got %0d wrap pulses, required 1", wraps);
        end
        $display("full_scan: wraps=%0d final sel=%0d", wraps, sel);
    endtask

    task automatic test_short_limit();
        bit found = 0;
        do_reset();
        limit = 3'd2; mode = 1; en = 1;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            checks++;
            if ({y, sel, wrap} !== {exp_y, exp_sel, exp_wrap}) begin
                errors++;
                $display("FAIL short_limit: got sel=%0d wrap=%b, required sel=%0d wrap=%b", sel, wrap, exp_sel, exp_wrap);
            end
            if (i > 20 && sel == 3'd2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL short_limit_reach2: SEL never reached 2 in cycle budget, required 2");
        end
        limit = 3'd1;
        found = 0;
        for (int i = 0; i < PRESCALE + 2 && !found; i++) begin
            tick();
            if (sel !== 3'd2) begin
                found = 1;
                checks++;
                if ({sel, wrap} !== {3'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL limit_lowered: got sel=%0d wrap=%b, required sel=0 wrap=1", sel, wrap);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL limit_lowered_step: SEL stayed at 2 for the whole cycle budget, required step to 0");
        end
        $display("short_limit: sel=%0d wrap=%b", sel, wrap);
    endtask

    task automatic test_enable_freeze();
        logic [N-1:0] held;
        do_reset();
        limit = 3'd7; mode = 1; en = 1;
        for (int i = 0; i < 3 + PRESCALE; i++) tick();  // counter is at 2 after one step
        held = sel;
        en = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({y, sel} !== {LINES'(0), held}) begin
                errors++;
                $display("FAIL freeze: got y=%b sel=%0d, required y=0 sel=%0d", y, sel, held);
            end
        end
        en = 1;
        tick();
        checks++;
        if (sel !== held || y !== LINES'(1 << held)) begin
            errors++;
            $display("FAIL freeze_resume1: got sel=%0d y=%b, required sel=%0d", sel, y, held);
        end
        tick();
        checks++;
        if (sel !== held + 1'b1 || sel !== exp_sel) begin
            errors++;
            $display("FAIL freeze_resume2: got sel=%0d, required %0d", sel, held + 1'b1);
        end
        $display("enable_freeze: held=%0d sel=%0d", held, sel);
    endtask

    task automatic test_mode_switch();
        bit found = 0;
        do_reset();
        limit = 3'd7; mode = 1; en = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (sel == 3'd3) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mode_reach3: SEL never reached 3, required 3");
        end
        mode = 0; w = 3'd6;
        tick();
        checks++;
        if ({sel, y} !== {3'd6, 8'b0100_0000}) begin
            errors++;
            $display("FAIL mode_to_direct: got sel=%0d y=%b, required sel=6", sel, y);
        end
        mode = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sel !== 3'd6) begin
                errors++;
                $display("FAIL mode_to_scan_hold: cyc=%0d got sel=%0d, required 6", i, sel);
            end
        end
        tick();
        checks++;
        if (sel !== 3'd7) begin
            errors++;
            $display("FAIL mode_to_scan_step: got sel=%0d, required 7", sel);
        end
        $display("mode_switch: sel=%0d", sel);
    endtask

    task automatic test_async_reset();
        bit found = 0;
        do_reset();
        limit = 3'd7; mode = 1; en = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (sel == 3'd4) found = 1;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (!found || {y, sel, wrap} !== {LINES'(0), N'(0), 1'b0}) begin
            errors++;
            $display("FAIL async_reset: found4=%0d got y=%b sel=%0d wrap=%b, required zeros", found, y, sel, wrap);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({y, sel, wrap} !== {exp_y, exp_sel, exp_wrap} || sel !== ((i == 4) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL async_restart: cyc=%0d got sel=%0d y=%b, required sel=%0d", i, sel, y, exp_sel);
            end
        end
        $display("async_reset: sel=%0d", sel);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            w     = N'($urandom);
            if ($urandom_range(0, 29) == 0) limit = N'($urandom);
            tick();
            checks++;
            if ({y, sel, wrap} !== {exp_y, exp_sel, exp_wrap} || $countones(y) > 1) begin
                errors++;
                $display("FAIL random: cyc=%0d got y=%b sel=%0d wrap=%b, required y=%b sel=%0d wrap=%b", i, y, sel, wrap, exp_y, exp_sel, exp_wrap);
            end
        end
        $display("random: 400 cycles done, sel=%0d", sel);
    endtask

    initial begin
        rst = 1'b0; en = 0; mode = 0; w = 0; limit = 0;
        model_reset();
        #2;
        test_reset();
        test_direct();
        test_full_scan();
        test_short_limit();
        test_enable_freeze();
        test_mode_switch();
        test_async_reset();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
